// File: rtl/ncc_pkg.sv
// Shared definitions for the NCC descriptor-load path: geometry, pixel/word types and packer states.
package ncc_pkg;

    localparam int unsigned NCC_DESC_PIXELS  = 256;
    localparam int unsigned NCC_PIX_PER_WORD = 4;
    localparam int unsigned NCC_DESC_WORDS   = NCC_DESC_PIXELS / NCC_PIX_PER_WORD;
    localparam int unsigned NCC_PIX_W        = 8;
    localparam int unsigned NCC_WORD_W       = NCC_PIX_W * NCC_PIX_PER_WORD;
    localparam int unsigned NCC_LANE_W       = $clog2(NCC_PIX_PER_WORD);
    localparam int unsigned NCC_WIDX_W       = $clog2(NCC_DESC_WORDS);

    typedef enum logic {PK_IDLE, PK_PACK} packState_t;

    typedef logic [NCC_PIX_W-1:0]  pixel_t;
    typedef logic [NCC_WORD_W-1:0] word_t;

endpackage

// File: rtl/byte_lane_packer.sv
// Four-lane pixel assembly register plus the registered output word and its one-cycle strobe.
module byte_lane_packer
    import ncc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  accept_i,
    input  logic [NCC_LANE_W-1:0] lane_i,
    input  pixel_t                pix_i,
    output word_t                 word_o,
    output logic                  strobe_o
);

    localparam logic [NCC_LANE_W-1:0] LAST_LANE = NCC_LANE_W'(NCC_PIX_PER_WORD - 1);

    logic [NCC_PIX_PER_WORD-1:0][NCC_PIX_W-1:0] lanes_q, lanes_d;
    word_t                                      word_q, word_d;
    logic                                       strobe_q, strobe_d;
    logic [NCC_LANE_W-1:0]                      slot_c;

    // Lane 0 lands in the most significant byte, so the packed slot is mirrored.
    assign slot_c = LAST_LANE - lane_i;

    always_comb begin
        lanes_d  = lanes_q;
        word_d   = word_q;
        strobe_d = 1'b0;
        if (accept_i) begin
            lanes_d[slot_c] = pix_i;
            if (lane_i == LAST_LANE) begin
                word_d   = word_t'(lanes_d);
                strobe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lanes_q  <= '0;
            word_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            lanes_q  <= lanes_d;
            word_q   <= word_d;
            strobe_q <= strobe_d;
        end
    end

    assign word_o   = word_q;
    assign strobe_o = strobe_q;

endmodule

// File: rtl/desc_word_packer.sv
// Packs a 256-pixel raster descriptor into exactly 64 strobed 32-bit words for the PE grid loader.
module desc_word_packer
    import ncc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  pix_valid,
    input  logic [NCC_PIX_W-1:0]  pix_data,
    output logic                  pix_ready,
    output logic                  desc_data_ready,
    output logic [NCC_WORD_W-1:0] desc_data_in,
    output logic                  busy,
    output logic                  done,
    output logic [NCC_WIDX_W-1:0] word_idx
);

    localparam logic [NCC_LANE_W-1:0] LAST_LANE = NCC_LANE_W'(NCC_PIX_PER_WORD - 1);
    localparam logic [NCC_WIDX_W-1:0] LAST_WORD = NCC_WIDX_W'(NCC_DESC_WORDS - 1);

    packState_t            state_q, state_d;
    logic [NCC_LANE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [NCC_WIDX_W-1:0] word_cnt_q, word_cnt_d;
    logic [NCC_WIDX_W-1:0] word_idx_q, word_idx_d;
    logic                  done_q, done_d;
    logic                  accept_c;

    // Next-state, counters and the registered done/word_idx updates.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        word_idx_d = word_idx_q;
        done_d     = 1'b0;
        accept_c   = 1'b0;
        case (state_q)
            PK_IDLE: begin
                if (start) begin
                    state_d    = PK_PACK;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                end
            end
            PK_PACK: begin
                accept_c = pix_valid;
                if (pix_valid) begin
                    byte_cnt_d = byte_cnt_q + NCC_LANE_W'(1);
                    if (byte_cnt_q == LAST_LANE) begin
                        word_idx_d = word_cnt_q;
                        word_cnt_d = word_cnt_q + NCC_WIDX_W'(1);
                        // Leaving on the last word's edge lets a waiting start chain the next descriptor.
                        if (word_cnt_q == LAST_WORD) begin
                            state_d = PK_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            default: state_d = PK_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PK_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            word_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            word_idx_q <= word_idx_d;
            done_q     <= done_d;
        end
    end

    byte_lane_packer u_lanes (
        .clk      (clk),
        .rst      (rst),
        .accept_i (accept_c),
        .lane_i   (byte_cnt_q),
        .pix_i    (pix_data),
        .word_o   (desc_data_in),
        .strobe_o (desc_data_ready)
    );

    assign pix_ready = (state_q == PK_PACK);
    assign busy      = (state_q == PK_PACK);
    assign done      = done_q;
    assign word_idx  = word_idx_q;

endmodule

// File: tb/tb_desc_word_packer.sv
// Scoreboard bench for desc_word_packer: driver queues expected words, monitor checks every strobe and hold cycle.
module tb_desc_word_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        pix_valid = 1'b0;
    logic [7:0]  pix_data = 8'h00;
    logic        pix_ready;
    logic        desc_data_ready;
    logic [31:0] desc_data_in;
    logic        busy;
    logic        done;
    logic [5:0]  word_idx;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  idx;
        logic        last;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          n_strobe = 0;
    logic [31:0] exp_hold = 32'h0;

    desc_word_packer dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .pix_valid       (pix_valid),
        .pix_data        (pix_data),
        .pix_ready       (pix_ready),
        .desc_data_ready (desc_data_ready),
        .desc_data_in    (desc_data_in),
        .busy            (busy),
        .done            (done),
        .word_idx        (word_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic [7:0] pix(input int mode, input int i);
        return (mode == 0) ? 8'(i) : 8'hAA;
    endfunction

    // Feeds bytes 0..stop_at-1 of a descriptor, queuing each completed word with its expected strobe cycle.
    task automatic send_desc(input int mode, input bit stall, input bit poke, input int stop_at);
        int          i = 0;
        int          w = 0;
        int          guard = 0;
        logic [31:0] acc = 32'h0;
        exp_t        e;
        while (i < stop_at && guard < 3000) begin
            pix_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_data  = pix_valid ? pix(mode, i) : 8'h5A;
            if (poke) start = (i >= 80 && i < 83);
            @(negedge clk);
            if (pix_valid && pix_ready) begin
                acc = {acc[23:0], pix_data};
                if (i % 4 == 3) begin
                    e.data = acc;
                    e.idx  = 6'(w);
                    e.last = (w == 63);
                    e.cyc  = cyc + 1;
                    sb.push_back(e);
                    w++;
                end
                i++;
            end
            @(posedge clk);
            #1;
            guard++;
        end
        pix_valid = 1'b0;
        if (i < stop_at) check("send_timeout", 32'(i), 32'(stop_at));
    endtask

    // Monitor: every strobe must match the queue head; between strobes the word holds and done stays low.
    initial begin : monitor
        logic r;
        exp_t e;
        forever begin
            @(posedge clk);
            r = rst;
            @(negedge clk);
            if (r) exp_hold = 32'h0;
            if (desc_data_ready === 1'b1) begin
                n_strobe++;
                check("strobe_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("word_data", desc_data_in, e.data);
                    check("word_idx", 32'(word_idx), 32'(e.idx));
                    check("done_with_strobe", 32'(done), 32'(e.last));
                    check("busy_with_strobe", 32'(busy), 32'(!e.last));
                    check("strobe_latency", 32'(cyc), 32'(e.cyc));
                    exp_hold = e.data;
                end
            end else begin
                check("data_hold", desc_data_in, exp_hold);
                check("done_no_strobe", 32'(done), 32'd0);
            end
        end
    end

    initial begin : stim
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_strobe", 32'(desc_data_ready), 32'd0);
        check("rst_data", desc_data_in, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_word_idx", 32'(word_idx), 32'd0);
        @(posedge clk);
        #1;

        // pix_valid in IDLE is ignored
        pix_valid = 1'b1;
        pix_data  = 8'h77;
        repeat (10) begin
            @(negedge clk);
            check("idle_pix_ready", 32'(pix_ready), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;

        // Full rate
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_desc(0, 1'b0, 1'b0, 256);
        repeat (3) @(posedge clk);
        #1;

        // Random stalls
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_desc(0, 1'b1, 1'b0, 256);
        repeat (3) @(posedge clk);
        #1;

        // start pulsed mid-descriptor
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_desc(0, 1'b0, 1'b1, 256);
        repeat (3) @(posedge clk);
        #1;

        // Back-to-back with start held through done
        start = 1'b1;
        @(posedge clk);
        #1;
        send_desc(0, 1'b0, 1'b0, 256);
        send_desc(0, 1'b0, 1'b0, 256);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset right after word 10's strobe
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_desc(0, 1'b0, 1'b0, 44);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_pix_ready", 32'(pix_ready), 32'd0);
        check("mid_rst_strobe", 32'(desc_data_ready), 32'd0);
        check("mid_rst_data", desc_data_in, 32'h0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_word_idx", 32'(word_idx), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fresh descriptor of 0xAA bytes
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        send_desc(1, 1'b0, 1'b0, 256);
        repeat (8) @(posedge clk);
        #1;

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("strobe_total", 32'(n_strobe), 32'd395);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
